// File: rtl/rc_cpl_reassembly_if.sv
// rtl/rc_cpl_reassembly_if.sv - RC payload stream and completion-done channel
interface rc_cpl_reassembly_if #(
  parameter int TAG_W = 5,
  parameter int OFF_W = 7
);
  logic             rc_valid;
  logic             rc_payload_last;
  logic [255:0]     rc_payload;
  logic [7:0]       rc_payload_dw_keep;
  logic [95:0]      rc_descriptor;

  logic             cpl_done_valid;
  logic             cpl_done_ready;
  logic [TAG_W-1:0] cpl_done_tag;
  logic [OFF_W:0]   cpl_done_beats;
  logic             cpl_done_err;

  modport master (
    output rc_valid, rc_payload_last, rc_payload, rc_payload_dw_keep, rc_descriptor,
    output cpl_done_ready,
    input  cpl_done_valid, cpl_done_tag, cpl_done_beats, cpl_done_err
  );

  modport slave (
    input  rc_valid, rc_payload_last, rc_payload, rc_payload_dw_keep, rc_descriptor,
    input  cpl_done_ready,
    output cpl_done_valid, cpl_done_tag, cpl_done_beats, cpl_done_err
  );
endinterface

// File: rtl/rc_cpl_reassembly.sv
// rtl/rc_cpl_reassembly.sv - tag-indexed RC completion reassembly with done FIFO
// Optional DW length check per request: define RC_CPL_LEN_CHECK_EN.
module rc_cpl_reassembly #(
  parameter int TAG_NUM    = 32,
  parameter int MAX_BEATS  = 128,
  parameter int DONE_DEPTH = 4,
  localparam int TAG_W     = $clog2(TAG_NUM),
  localparam int OFF_W     = $clog2(MAX_BEATS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rc_cpl_reassembly_if.slave     bus,
  input  logic                   tag_alloc_valid,
  input  logic [TAG_W-1:0]       tag_alloc_tag,
  output logic                   buf_wr_en,
  output logic [TAG_W+OFF_W-1:0] buf_wr_addr,
  output logic [255:0]           buf_wr_data,
  output logic [7:0]             buf_wr_dw_en,
  output logic                   err_unexp,
  output logic                   err_fifo_ovf
);

  localparam int             PTR_W   = $clog2(DONE_DEPTH);
  localparam int             DONE_W  = TAG_W + OFF_W + 2;
  localparam logic [OFF_W:0] MAX_CNT = (OFF_W+1)'(MAX_BEATS);

  typedef enum logic {S_IDLE, S_BODY} state_t;

  state_t state_q, state_d;
  logic   first_beat;

  logic [3:0] d_err_code;
  logic       d_req_done;
  logic [2:0] d_status;
  logic       d_poison;
  logic [7:0] d_tag;

  assign d_err_code = bus.rc_descriptor[15:12];
  assign d_req_done = bus.rc_descriptor[30];
  assign d_status   = bus.rc_descriptor[45:43];
  assign d_poison   = bus.rc_descriptor[46];
  assign d_tag      = bus.rc_descriptor[71:64];

  logic [TAG_NUM-1:0] active_q;
  logic [TAG_NUM-1:0] err_q;
  logic [OFF_W:0]     cnt_q [TAG_NUM];

  logic [TAG_W-1:0] cur_tag_q;
  logic             cur_drop_q;

  logic [TAG_W-1:0] beat_tag;
  logic             first_drop;
  logic             beat_drop;
  logic             beat_ok;
  logic             at_max;
  logic             do_write;
  logic [OFF_W:0]   cnt_cur;
  logic [OFF_W:0]   cnt_next;
  logic             desc_err;
  logic             beat_err;
  logic             err_next;
  logic             done_push;
  logic             done_err;
  logic             len_bad;

  always_comb begin
    state_d    = state_q;
    first_beat = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rc_valid) begin
          first_beat = 1'b1;
          state_d    = bus.rc_payload_last ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        if (bus.rc_valid && bus.rc_payload_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Tag and drop verdict are decided once on the first beat and reused for the rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_tag_q  <= '0;
      cur_drop_q <= 1'b0;
    end else if (first_beat) begin
      cur_tag_q  <= d_tag[TAG_W-1:0];
      cur_drop_q <= first_drop;
    end
  end

  always_comb begin
    first_drop = ((d_tag >> TAG_W) != 8'd0) || !active_q[d_tag[TAG_W-1:0]];
    beat_tag   = first_beat ? d_tag[TAG_W-1:0] : cur_tag_q;
    beat_drop  = first_beat ? first_drop : cur_drop_q;
    beat_ok    = bus.rc_valid && !beat_drop;
    cnt_cur    = cnt_q[beat_tag];
    at_max     = (cnt_cur == MAX_CNT);
    do_write   = beat_ok && !at_max;
    cnt_next   = do_write ? cnt_cur + 1'b1 : cnt_cur;
    desc_err   = (d_status != 3'd0) || d_poison || (d_err_code != 4'd0);
    beat_err   = desc_err || at_max;
    err_next   = err_q[beat_tag] | beat_err;
    done_push  = beat_ok && bus.rc_payload_last && (d_req_done || (d_status != 3'd0));
    done_err   = err_next | len_bad;
  end

`ifdef RC_CPL_LEN_CHECK_EN
  localparam int ACC_W = OFF_W + 6;

  logic [10:0]      d_dw_cnt;
  logic [ACC_W-1:0] acc_q [TAG_NUM];
  logic [ACC_W-1:0] sum_q [TAG_NUM];
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] sum_next;
  logic [3:0]       keep_pop;

  assign d_dw_cnt = bus.rc_descriptor[42:32];

  // acc counts DWs actually written; sum counts DWs the completers announced
  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < 8; i++) begin
      keep_pop = keep_pop + {3'd0, bus.rc_payload_dw_keep[i]};
    end
    acc_next = acc_q[beat_tag] + (do_write ? ACC_W'(keep_pop) : '0);
    sum_next = sum_q[beat_tag] + (first_beat ? ACC_W'(d_dw_cnt) : '0);
    len_bad  = (acc_next != sum_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        acc_q[i] <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      if (beat_ok) begin
        acc_q[beat_tag] <= acc_next;
        sum_q[beat_tag] <= sum_next;
      end
      if (tag_alloc_valid) begin
        acc_q[tag_alloc_tag] <= '0;
        sum_q[tag_alloc_tag] <= '0;
      end
    end
  end
`else
  assign len_bad = 1'b0;
`endif

  // Alloc is applied after the completion update so it wins on a same-tag collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      err_q    <= '0;
      for (int i = 0; i < TAG_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      if (beat_ok) begin
        cnt_q[beat_tag] <= cnt_next;
        err_q[beat_tag] <= err_next;
        if (done_push) begin
          active_q[beat_tag] <= 1'b0;
        end
      end
      if (tag_alloc_valid) begin
        active_q[tag_alloc_tag] <= 1'b1;
        cnt_q[tag_alloc_tag]    <= '0;
        err_q[tag_alloc_tag]    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_wr_en    <= 1'b0;
      buf_wr_addr  <= '0;
      buf_wr_data  <= '0;
      buf_wr_dw_en <= '0;
      err_unexp    <= 1'b0;
    end else begin
      buf_wr_en <= do_write;
      err_unexp <= first_beat && first_drop;
      if (do_write) begin
        buf_wr_addr  <= {beat_tag, cnt_cur[OFF_W-1:0]};
        buf_wr_data  <= bus.rc_payload;
        buf_wr_dw_en <= bus.rc_payload_dw_keep;
      end
    end
  end

  logic [DONE_W-1:0] fifo_mem [DONE_DEPTH];
  logic [PTR_W:0]    wr_ptr_q;
  logic [PTR_W:0]    rd_ptr_q;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;
  logic              fifo_push;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_pop   = !fifo_empty && bus.cpl_done_ready;
  assign fifo_push  = done_push && (!fifo_full || fifo_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_fifo_ovf <= 1'b0;
      for (int i = 0; i < DONE_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {beat_tag, cnt_next, done_err};
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (done_push && fifo_full && !fifo_pop) begin
        err_fifo_ovf <= 1'b1;
      end
    end
  end

  assign bus.cpl_done_valid = !fifo_empty;
  assign {bus.cpl_done_tag, bus.cpl_done_beats, bus.cpl_done_err} = fifo_mem[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: tb/tb_rc_cpl_reassembly.sv
// tb/tb_rc_cpl_reassembly.sv - randomized bench for rc_cpl_reassembly against a request-level model
module tb_rc_cpl_reassembly;

  localparam int TAG_NUM   = 32;
  localparam int MAX_BEATS = 128;
  localparam int TAG_W     = 5;
  localparam int OFF_W     = 7;
  localparam int DEPTH     = 4;
  localparam int AW        = TAG_W + OFF_W;
  localparam int DW_BITS   = TAG_W + OFF_W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc_cpl_reassembly_if #(.TAG_W(TAG_W), .OFF_W(OFF_W)) bus ();

  logic             tag_alloc_valid;
  logic [TAG_W-1:0] tag_alloc_tag;
  logic             buf_wr_en;
  logic [AW-1:0]    buf_wr_addr;
  logic [255:0]     buf_wr_data;
  logic [7:0]       buf_wr_dw_en;
  logic             err_unexp;
  logic             err_fifo_ovf;

  rc_cpl_reassembly dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .tag_alloc_valid (tag_alloc_valid),
    .tag_alloc_tag   (tag_alloc_tag),
    .buf_wr_en       (buf_wr_en),
    .buf_wr_addr     (buf_wr_addr),
    .buf_wr_data     (buf_wr_data),
    .buf_wr_dw_en    (buf_wr_dw_en),
    .err_unexp       (err_unexp),
    .err_fifo_ovf    (err_fifo_ovf)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [279:0] got, input logic [279:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [7:0]    keep;
    logic [255:0]  data;
  } wr_t;

  // Request-level reference state
  bit                 m_active [TAG_NUM];
  int                 m_cnt    [TAG_NUM];
  bit                 m_err    [TAG_NUM];
  int                 m_dw     [TAG_NUM];
  int                 m_dwsum  [TAG_NUM];
  bit                 m_ovf;
  wr_t                exp_wr[$];
  int                 exp_unexp[$];
  logic [DW_BITS-1:0] exp_done[$];

  function automatic int popc(input logic [7:0] k);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(k[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TAG_NUM; i++) begin
      m_active[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_dw[i] = 0; m_dwsum[i] = 0;
    end
    m_ovf = 0;
    exp_wr.delete();
    exp_unexp.delete();
    exp_done.delete();
  endtask

  task automatic model_alloc(input int t);
    m_active[t] = 1; m_cnt[t] = 0; m_err[t] = 0; m_dw[t] = 0; m_dwsum[t] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.rc_valid    = 1'b0;
      tag_alloc_valid = 1'b0;
    end
  endtask

  task automatic alloc(input int t);
    @(posedge clk); #1;
    bus.rc_valid    = 1'b0;
    tag_alloc_valid = 1'b1;
    tag_alloc_tag   = TAG_W'(t);
    model_alloc(t);
  endtask

  task automatic send_cpl(input int tag8, input int nbeats, input int dwc, input int status,
                          input bit poison, input int ecode, input bit req,
                          input logic [7:0] keep_last, input int alloc_at, input bit no_last);
    logic [95:0]  d;
    logic [255:0] pl;
    logic [7:0]   keep;
    bit           drop;
    bit           last;
    bit           e;
    int           t;
    d        = '0;
    d[11:0]  = 12'($urandom);
    d[15:12] = 4'(ecode);
    d[30]    = req;
    d[42:32] = 11'(dwc);
    d[45:43] = 3'(status);
    d[46]    = poison;
    d[71:64] = 8'(tag8);
    t        = tag8 % TAG_NUM;
    drop     = 0;
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk); #1;
      if (rand_ready) bus.cpl_done_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) pl[i*32 +: 32] = $urandom;
      keep = (b == nbeats - 1) ? keep_last : 8'hFF;
      last = (b == nbeats - 1) && !no_last;
      bus.rc_valid           = 1'b1;
      bus.rc_payload_last    = last;
      bus.rc_payload         = pl;
      bus.rc_payload_dw_keep = keep;
      bus.rc_descriptor      = d;
      tag_alloc_valid        = (b == alloc_at);
      tag_alloc_tag          = TAG_W'(t);
      if (b == 0) begin
        drop = (tag8 >= TAG_NUM) || !m_active[t];
        if (drop) exp_unexp.push_back(cyc + 1);
        else m_dwsum[t] += dwc;
      end
      if (!drop) begin
        if (m_cnt[t] < MAX_BEATS) begin
          exp_wr.push_back('{cyc + 1, AW'((t << OFF_W) + m_cnt[t]), keep, pl});
          m_cnt[t]++;
          m_dw[t] += popc(keep);
        end else begin
          m_err[t] = 1;
        end
        if (status != 0 || poison || ecode != 0) m_err[t] = 1;
        if (last && (req || status != 0)) begin
          e = m_err[t];
`ifdef RC_CPL_LEN_CHECK_EN
          if (m_dw[t] != m_dwsum[t]) e = 1;
`endif
          if (exp_done.size() >= DEPTH && !bus.cpl_done_ready) m_ovf = 1;
          else exp_done.push_back({TAG_W'(t), (OFF_W+1)'(m_cnt[t]), e});
          m_active[t] = 0;
        end
      end
      if (b == alloc_at) model_alloc(t);
    end
  endtask

  bit mon_en = 0;

  always @(negedge clk) begin
    bit                 exp_en;
    wr_t                h;
    logic [DW_BITS-1:0] ed;
    if (mon_en) begin
      exp_en = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
      check("wr_en", buf_wr_en, exp_en);
      if (exp_en) begin
        h = exp_wr.pop_front();
        if (buf_wr_en) check("wr_beat", {buf_wr_addr, buf_wr_dw_en, buf_wr_data}, {h.addr, h.keep, h.data});
      end
      exp_en = (exp_unexp.size() > 0) && (exp_unexp[0] == cyc);
      check("err_unexp", err_unexp, exp_en);
      if (exp_en) void'(exp_unexp.pop_front());
      if (bus.cpl_done_valid && bus.cpl_done_ready) begin
        if (exp_done.size() > 0) begin
          ed = exp_done.pop_front();
          check("done", {bus.cpl_done_tag, bus.cpl_done_beats, bus.cpl_done_err}, ed);
        end else begin
          check("done_extra", bus.cpl_done_valid, 1'b0);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_wr_en", buf_wr_en, 1'b0);
    check("rst_wr_addr", buf_wr_addr, '0);
    check("rst_unexp", err_unexp, 1'b0);
    check("rst_ovf", err_fifo_ovf, 1'b0);
    check("rst_done_valid", bus.cpl_done_valid, 1'b0);
    check("rst_done_fields", {bus.cpl_done_tag, bus.cpl_done_beats, bus.cpl_done_err}, '0);
  endtask

  task automatic do_reset();
    idle(3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_clear();
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int tag8, nb, dwc, st, aat;
    logic [7:0] kl;
    bus.rc_valid = 0; bus.rc_payload_last = 0; bus.rc_payload = '0;
    bus.rc_payload_dw_keep = '0; bus.rc_descriptor = '0; bus.cpl_done_ready = 1'b1;
    tag_alloc_valid = 0; tag_alloc_tag = '0;
    model_clear();
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1;

    // Single 4-beat request
    alloc(3);
    send_cpl(3, 4, 32, 0, 0, 0, 1, 8'hFF, -1, 0);
    idle(1);
    @(negedge clk);
    check("done_lat", bus.cpl_done_valid, 1'b1);

    // Split request: 2 beats then 1 beat
    alloc(5);
    send_cpl(5, 2, 16, 0, 0, 0, 0, 8'hFF, -1, 0);
    send_cpl(5, 1, 4, 0, 0, 0, 1, 8'h0F, -1, 0);

    // Unarmed tag and out-of-range tag
    send_cpl(7, 2, 16, 0, 0, 0, 1, 8'hFF, -1, 0);
    send_cpl(40, 1, 8, 0, 0, 0, 1, 8'hFF, -1, 0);

    // Status error ends the request; tag is then inactive
    alloc(2);
    send_cpl(2, 1, 8, 1, 0, 0, 0, 8'hFF, -1, 0);
    send_cpl(2, 1, 8, 0, 0, 0, 1, 8'hFF, -1, 0);

    // Alloc colliding with done, and alloc colliding with a first beat
    alloc(20);
    send_cpl(20, 2, 16, 0, 0, 0, 1, 8'hFF, 1, 0);
    send_cpl(20, 1, 8, 0, 0, 0, 1, 8'hFF, -1, 0);
    send_cpl(21, 1, 8, 0, 0, 0, 1, 8'hFF, 0, 0);
    send_cpl(21, 1, 8, 0, 0, 0, 1, 8'hFF, -1, 0);

    // Overlong completion saturates at MAX_BEATS
    alloc(1);
    send_cpl(1, 129, 1024, 0, 0, 0, 1, 8'hFF, -1, 0);

    // Reset in the middle of a completion
    alloc(9);
    send_cpl(9, 2, 32, 0, 0, 0, 1, 8'hFF, -1, 1);
    do_reset();
    send_cpl(9, 1, 8, 0, 0, 0, 1, 8'hFF, -1, 0);
    alloc(9);
    send_cpl(9, 1, 8, 0, 0, 0, 1, 8'hFF, -1, 0);

    // Done FIFO overflow with ready held low
    idle(2);
    bus.cpl_done_ready = 1'b0;
    for (int i = 10; i < 15; i++) alloc(i);
    for (int i = 10; i < 15; i++) send_cpl(i, 1, 8, 0, 0, 0, 1, 8'hFF, -1, 0);
    idle(2);
    @(negedge clk);
    check("ovf_set", err_fifo_ovf, 1'b1);
    check("stall_valid", bus.cpl_done_valid, 1'b1);
    check("stall_head", bus.cpl_done_tag, TAG_W'(10));
    @(posedge clk); #1;
    bus.cpl_done_ready = 1'b1;
    idle(8);

    // Randomized traffic
    rand_ready = 1;
    repeat (250) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 25) begin
        alloc($urandom_range(0, TAG_NUM - 1));
      end else if (r < 30) begin
        idle($urandom_range(1, 3));
      end else begin
        tag8 = ($urandom_range(0, 9) == 0) ? $urandom_range(32, 255) : $urandom_range(0, TAG_NUM - 1);
        nb   = $urandom_range(1, 5);
        kl   = 8'hFF >> $urandom_range(0, 7);
        dwc  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : (nb - 1) * 8 + popc(kl);
        st   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
        aat  = (tag8 < TAG_NUM && $urandom_range(0, 14) == 0) ? $urandom_range(0, nb - 1) : -1;
        send_cpl(tag8, nb, dwc, st, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0) ? 4'h3 : 0,
                 1'($urandom_range(0, 1)), kl, aat, 0);
      end
    end
    rand_ready = 0;
    idle(1);
    bus.cpl_done_ready = 1'b1;
    idle(12);
    @(negedge clk);
    check("wr_left", exp_wr.size(), 0);
    check("unexp_left", exp_unexp.size(), 0);
    check("done_left", exp_done.size(), 0);
    check("ovf_final", err_fifo_ovf, m_ovf);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
